sdram_arb: RTL
==============

Name: sdram_arb

Overview:
- Three-way arbiter and sequencer for the single MiSTer SDRAM read/write port.
- Shares the port between three requesters: the CPU memory interface (port 0), the HPS ROM/ioctl download path (port 1) and the backup-memory (BMP) save/load engine (port 2).
- Converts per-port level requests into one-cycle SDRAM_RD/SDRAM_WE strobes, tracks the RDY handshake to completion and returns a per-port acknowledge plus latched read data.

Parameters:
- AW, 25, SDRAM word address width.
- LO_TIMEOUT, 4, max cycles to wait for RDY to fall after a strobe before treating the access as complete.

Ports:
- SDRAM_CLK  in  1  sole clock. Requesters are synchronous to it.
- RESET  in  1  synchronous, active-high reset.
- Pn_REQ (n=0..2)  in  1  request. Held high until Pn_ACK.
- Pn_WE  in  1  1=write, 0=read. Stable while Pn_REQ.
- Pn_ADDR  in  AW  access address. Stable while Pn_REQ.
- Pn_DIN  in  32  write data.
- Pn_BE  in  4  write byte enables, active-high.
- Pn_ACK  out  1  one-cycle completion pulse.
- DO  out  32  read data, shared. Valid from the cycle of any read ACK until the next read ACK.
- SDRAM_CLKREF  out  1  OR of all Pn_REQ.
- SDRAM_RADDR / SDRAM_WADDR  out  AW  registered address of the granted port.
- SDRAM_DIN  out  32  registered write data.
- SDRAM_BE  out  4  registered byte enables. 4'hF on reads.
- SDRAM_RD / SDRAM_WE  out  1  one-cycle strobes.
- SDRAM_RD_RDY / SDRAM_WE_RDY  in  1  controller idle/done indications.
- SDRAM_DOUT  in  32  read data.

Behaviour:
- Reset:
  - State=IDLE.
  - All Pn_ACK=0, SDRAM_RD=SDRAM_WE=0, DO=0, address/data/BE registers=0, rr pointer=port1.
  - Timeout counter=0.
  - SDRAM_CLKREF is combinational and follows the REQ inputs even in reset.
- Grant (evaluated in IDLE only):
  - Port 0 wins over ports 1/2.
  - Between 1 and 2, round-robin. The rr pointer moves to the other port after each ACK to port 1 or 2.
  - The grant is fixed until ACK. A higher-priority request arriving mid-access waits.
- States:
  - IDLE: if any REQ, latch grant, WE, ADDR, DIN and BE (BE forced to F for reads) -> ISSUE.
  - ISSUE: wait until the relevant RDY (RD_RDY for reads, WE_RDY for writes) =1. In that cycle assert the matching strobe for exactly one cycle, clear the counter -> WAIT_LO.
  - WAIT_LO:
    - RDY=0 -> WAIT_HI.
    - Otherwise increment the counter. When the counter reaches LO_TIMEOUT-1, treat the access as complete -> DONE.
  - WAIT_HI: RDY=1 -> DONE. No timeout.
  - DONE: pulse Pn_ACK of the granted port. On a read, load DO from SDRAM_DOUT in the same cycle. -> IDLE.
- Strobes:
  - Never asserted outside ISSUE.
  - RD and WE are never asserted together.
  - At most one strobe per granted request.
- Latency, idle bus and controller ready:
  - Read REQ rise to ACK = 3 + controller busy time (IDLE, ISSUE, WAIT_LO, WAIT_HI≥1, DONE).
  - Back-to-back requests need 1 IDLE cycle between accesses.
- Requester rules:
  - Pn_REQ must drop in the cycle after Pn_ACK. If it is still high in IDLE, that is a new request.
  - A REQ dropped before ACK is a protocol violation. The arbiter completes the access anyway and still pulses ACK.
- Reset mid-operation:
  - Returns to IDLE immediately and no ACK is issued for the aborted access.
  - The first post-reset access still waits in ISSUE for RDY=1, so a controller finishing the stale access is absorbed.
- Simultaneous events:
  - REQ on all three ports in IDLE -> port 0.
  - Then ports 1 and 2 in rr order.

Test Plan:
- P0 read, addr 0x0100004. Controller drops RD_RDY 1 cycle after strobe and raises it 5 cycles later with DOUT=0xDEADBEEF -> one SDRAM_RD pulse with RADDR=0x0100004, then P0_ACK with DO=0xDEADBEEF, BE=F.
- P1 write, ADDR 0x1000010, DIN 0x12345678, BE 4'b0011 -> single SDRAM_WE pulse with WADDR/DIN/BE matching, P1_ACK, DO unchanged.
- P1 and P2 held continuously, P0 idle -> ACK order 1,2,1,2. Assert P0 during a P1 access -> P0 is served next, before P2.
- RD_RDY held low at request time for 10 cycles -> no strobe until RD_RDY=1, then exactly one strobe.
- Controller never drops RDY after the strobe -> ACK after LO_TIMEOUT cycles in WAIT_LO. No second strobe.
- RESET asserted in WAIT_HI -> no ACK, strobes 0, DO=0. A subsequent P2 read completes normally.

Source files
------------

// File: rtl/sdram_arb.sv
// Three-port arbiter/sequencer for the single MiSTer SDRAM read/write port.
// Port 0 has fixed priority; ports 1 and 2 alternate round-robin.
module sdram_arb #(
    parameter int AW         = 25,
    parameter int LO_TIMEOUT = 4
) (
    input  logic          SDRAM_CLK,
    input  logic          RESET,

    input  logic          P0_REQ,
    input  logic          P0_WE,
    input  logic [AW-1:0] P0_ADDR,
    input  logic [31:0]   P0_DIN,
    input  logic [3:0]    P0_BE,
    output logic          P0_ACK,

    input  logic          P1_REQ,
    input  logic          P1_WE,
    input  logic [AW-1:0] P1_ADDR,
    input  logic [31:0]   P1_DIN,
    input  logic [3:0]    P1_BE,
    output logic          P1_ACK,

    input  logic          P2_REQ,
    input  logic          P2_WE,
    input  logic [AW-1:0] P2_ADDR,
    input  logic [31:0]   P2_DIN,
    input  logic [3:0]    P2_BE,
    output logic          P2_ACK,

    output logic [31:0]   DO,

    output logic          SDRAM_CLKREF,
    output logic [AW-1:0] SDRAM_RADDR,
    output logic [AW-1:0] SDRAM_WADDR,
    output logic [31:0]   SDRAM_DIN,
    output logic [3:0]    SDRAM_BE,
    output logic          SDRAM_RD,
    output logic          SDRAM_WE,
    input  logic          SDRAM_RD_RDY,
    input  logic          SDRAM_WE_RDY,
    input  logic [31:0]   SDRAM_DOUT
);
    localparam int            CW       = (LO_TIMEOUT > 1) ? $clog2(LO_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LO_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic [2:0]           req, req_we;
    logic [2:0][AW-1:0]   req_addr;
    logic [2:0][31:0]     req_din;
    logic [2:0][3:0]      req_be;

    logic [1:0]    gnt, gnt_sel;
    logic          gnt_any;
    logic          rr;          // 0: port 1 is next among 1/2, 1: port 2
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [31:0]   din_r;
    logic [3:0]    be_r;
    logic [31:0]   do_r;
    logic          rdy_sel;
    logic          fire;
    logic          done;
    logic [2:0]    ack;

    assign req      = {P2_REQ,  P1_REQ,  P0_REQ};
    assign req_we   = {P2_WE,   P1_WE,   P0_WE};
    assign req_addr = {P2_ADDR, P1_ADDR, P0_ADDR};
    assign req_din  = {P2_DIN,  P1_DIN,  P0_DIN};
    assign req_be   = {P2_BE,   P1_BE,   P0_BE};

    assign SDRAM_CLKREF = |req;

    always_comb begin
        gnt_any = |req;
        gnt_sel = 2'd0;
        if (req[0])
            gnt_sel = 2'd0;
        else if (req[1] && req[2])
            gnt_sel = rr ? 2'd2 : 2'd1;
        else if (req[1])
            gnt_sel = 2'd1;
        else if (req[2])
            gnt_sel = 2'd2;
    end

    assign rdy_sel = we_r ? SDRAM_WE_RDY : SDRAM_RD_RDY;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE:    if (gnt_any) state_nxt = S_ISSUE;
            S_ISSUE:   if (rdy_sel) begin
                           state_nxt = S_WAIT_LO;
                           cnt_nxt   = '0;
                       end
            // A controller that never drops RDY must not stall the port forever.
            S_WAIT_LO: if (!rdy_sel)
                           state_nxt = S_WAIT_HI;
                       else if (cnt == CNT_LAST)
                           state_nxt = S_DONE;
                       else
                           cnt_nxt = cnt + 1'b1;
            S_WAIT_HI: if (rdy_sel) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge SDRAM_CLK) begin
        if (RESET) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge SDRAM_CLK) begin
        if (RESET) begin
            gnt    <= 2'd0;
            we_r   <= 1'b0;
            addr_r <= '0;
            din_r  <= '0;
            be_r   <= '0;
            rr     <= 1'b0;
            do_r   <= '0;
        end else begin
            if (state == S_IDLE && gnt_any) begin
                gnt    <= gnt_sel;
                we_r   <= req_we[gnt_sel];
                addr_r <= req_addr[gnt_sel];
                din_r  <= req_din[gnt_sel];
                be_r   <= req_we[gnt_sel] ? req_be[gnt_sel] : 4'hF;
            end
            if (state == S_DONE) begin
                if (!we_r)
                    do_r <= SDRAM_DOUT;
                if (gnt != 2'd0)
                    rr <= (gnt == 2'd1);
            end
        end
    end

    // Strobes and ACK are decoded from state so they can only appear in ISSUE/DONE.
    assign fire     = (state == S_ISSUE) && rdy_sel && !RESET;
    assign done     = (state == S_DONE) && !RESET;
    assign SDRAM_RD = fire && !we_r;
    assign SDRAM_WE = fire && we_r;
    assign ack      = done ? (3'b001 << gnt) : 3'b000;

    assign P0_ACK = ack[0];
    assign P1_ACK = ack[1];
    assign P2_ACK = ack[2];

    // Read data is forwarded in the ACK cycle and held afterwards.
    assign DO = (done && !we_r) ? SDRAM_DOUT : do_r;

    assign SDRAM_RADDR = addr_r;
    assign SDRAM_WADDR = addr_r;
    assign SDRAM_DIN   = din_r;
    assign SDRAM_BE    = be_r;

endmodule
